// File: rtl/tia_audio_poly_if.sv
// Register-file side of the polyphonic TIA audio block: per-channel control,
// frequency and volume in, raw channel bits and the summed mix out.
interface tia_audio_poly_if #(
  parameter int NUM_CH = 2,
  parameter int FREQ_W = 5,
  parameter int VOL_W  = 4,
  parameter int MIX_W  = VOL_W + $clog2(NUM_CH + 1)
);
  // Level-sampled bus, no handshake: AUDC/AUDF/AUDV are taken on every rising
  // CLK_30 edge and AUD/AUD_MIX are valid for the whole cycle after an edge.
  logic [4*NUM_CH-1:0]      AUDC;
  logic [FREQ_W*NUM_CH-1:0] AUDF;
  logic [VOL_W*NUM_CH-1:0]  AUDV;
  logic [NUM_CH-1:0]        AUD;
  logic [MIX_W-1:0]         AUD_MIX;

  modport master (output AUDC, AUDF, AUDV, input AUD, AUD_MIX);
  modport slave  (input AUDC, AUDF, AUDV, output AUD, AUD_MIX);
endinterface

// File: rtl/tia_audio_poly.sv
// NUM_CH-channel TIA-style tone/noise generator: per-channel divider, poly4/5/9
// LFSRs and div3/div31 prescalers, with a registered volume-weighted mix.
module tia_audio_poly #(
  parameter int NUM_CH = 2,
  parameter int FREQ_W = 5,
  parameter int VOL_W  = 4,
  parameter int MIX_W  = VOL_W + $clog2(NUM_CH + 1)
) (
  input logic              CLK_30,
  input logic              RESET,
  tia_audio_poly_if.slave  bus
);

  logic [FREQ_W-1:0] cnt_q   [NUM_CH];
  logic [FREQ_W-1:0] cnt_d   [NUM_CH];
  logic [1:0]        div3_q  [NUM_CH];
  logic [1:0]        div3_d  [NUM_CH];
  logic [4:0]        div31_q [NUM_CH];
  logic [4:0]        div31_d [NUM_CH];
  logic [3:0]        p4_q    [NUM_CH];
  logic [3:0]        p4_d    [NUM_CH];
  logic [4:0]        p5_q    [NUM_CH];
  logic [4:0]        p5_d    [NUM_CH];
  logic [8:0]        p9_q    [NUM_CH];
  logic [8:0]        p9_d    [NUM_CH];
  logic [3:0]        audc_q  [NUM_CH];
  logic [NUM_CH-1:0] aud_q;
  logic [NUM_CH-1:0] aud_d;
  logic [MIX_W-1:0]  mix_q;
  logic [MIX_W-1:0]  mix_d;

  always_comb begin
    aud_d = aud_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch]   = cnt_q[ch];
      div3_d[ch]  = div3_q[ch];
      div31_d[ch] = div31_q[ch];
      p4_d[ch]    = p4_q[ch];
      p5_d[ch]    = p5_q[ch];
      p9_d[ch]    = p9_q[ch];
      if (bus.AUDC[4*ch +: 4] != audc_q[ch]) begin
        // A control write restarts the prescalers but leaves the LFSRs running.
        cnt_d[ch]   = '0;
        div3_d[ch]  = '0;
        div31_d[ch] = '0;
      end else if (cnt_q[ch] == bus.AUDF[FREQ_W*ch +: FREQ_W]) begin
        cnt_d[ch]   = '0;
        div3_d[ch]  = (div3_q[ch] == 2'd2) ? 2'd0 : div3_q[ch] + 2'd1;
        div31_d[ch] = (div31_q[ch] == 5'd30) ? 5'd0 : div31_q[ch] + 5'd1;
        p5_d[ch]    = {p5_q[ch][3:0], p5_q[ch][4] ^ p5_q[ch][2]};
        p9_d[ch]    = {p9_q[ch][7:0], p9_q[ch][8] ^ p9_q[ch][4]};
        case (bus.AUDC[4*ch +: 4])
          4'h0, 4'hB: aud_d[ch] = 1'b1;
          4'h1: begin
            aud_d[ch] = p4_q[ch][3];
            p4_d[ch]  = {p4_q[ch][2:0], p4_q[ch][3] ^ p4_q[ch][2]};
          end
          4'h2: begin
            aud_d[ch] = p4_q[ch][3];
            if (div31_q[ch] == 5'd0 || div31_q[ch] == 5'd18)
              p4_d[ch] = {p4_q[ch][2:0], p4_q[ch][3] ^ p4_q[ch][2]};
          end
          4'h3: begin
            aud_d[ch] = p4_q[ch][3];
            if (p5_q[ch][4])
              p4_d[ch] = {p4_q[ch][2:0], p4_q[ch][3] ^ p4_q[ch][2]};
          end
          4'h4, 4'h5: aud_d[ch] = ~aud_q[ch];
          4'h6, 4'hA: aud_d[ch] = (div31_q[ch] < 5'd18);
          4'h7, 4'h9: aud_d[ch] = p5_q[ch][4];
          4'h8:       aud_d[ch] = p9_q[ch][8];
          4'hC, 4'hD: if (div3_q[ch] == 2'd2) aud_d[ch] = ~aud_q[ch];
          4'hE: if (div3_q[ch] == 2'd2 && div31_q[ch] < 5'd18) aud_d[ch] = ~aud_q[ch];
          4'hF: if (div3_q[ch] == 2'd2) aud_d[ch] = p5_q[ch][4];
          default: aud_d[ch] = aud_q[ch];
        endcase
      end else begin
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      end
    end
  end

  // Mix weights the bits already on AUD, so it trails AUD by one edge.
  always_comb begin
    mix_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      if (aud_q[ch]) mix_d = mix_d + MIX_W'(bus.AUDV[VOL_W*ch +: VOL_W]);
  end

  always_ff @(posedge CLK_30) begin
    if (RESET) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch]   <= '0;
        div3_q[ch]  <= '0;
        div31_q[ch] <= '0;
        p4_q[ch]    <= 4'hF;
        p5_q[ch]    <= 5'h1F;
        p9_q[ch]    <= 9'h1FF;
        audc_q[ch]  <= bus.AUDC[4*ch +: 4];
      end
      aud_q <= '0;
      mix_q <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch]   <= cnt_d[ch];
        div3_q[ch]  <= div3_d[ch];
        div31_q[ch] <= div31_d[ch];
        p4_q[ch]    <= p4_d[ch];
        p5_q[ch]    <= p5_d[ch];
        p9_q[ch]    <= p9_d[ch];
        audc_q[ch]  <= bus.AUDC[4*ch +: 4];
      end
      aud_q <= aud_d;
      mix_q <= mix_d;
    end
  end

  assign bus.AUD     = aud_q;
  assign bus.AUD_MIX = mix_q;

endmodule
